// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer: the PPU fills one bank while the VGA stage scans the other.
// Banks exchange at the end of a VGA line whose successor is a visible PPU line.
module ppu_line_buffer #(
    parameter int                LINE_W     = 256,
    parameter int                IDX_W      = 6,
    parameter int                FIRST_LINE = 1,
    parameter int                LAST_LINE  = 240,
    parameter int                H_LAST     = 799,
    parameter logic [IDX_W-1:0]  PAD_IDX    = IDX_W'('h0F)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             pix_eol,
    output logic             wr_ready,
    output logic             line_req,
    input  logic [9:0]       hc,
    input  logic [9:0]       vc,
    output logic [IDX_W-1:0] palette_disp_idx,
    output logic             overflow,
    output logic             underrun,
    input  logic             clr_err
);

    localparam int            PW       = $clog2(LINE_W);
    localparam logic [PW-1:0] PTR_LAST = PW'(LINE_W - 1);
    localparam logic [9:0]    V_LAST   = 10'd524;
    localparam logic [9:0]    H_END    = 10'(H_LAST);
    localparam logic [9:0]    V_FIRST  = 10'(FIRST_LINE);
    localparam logic [9:0]    V_LASTVIS = 10'(LAST_LINE);
    localparam logic [9:0]    LINE_V   = 10'(LINE_W);

    typedef enum logic [1:0] {W_FILL, W_PAD, W_FULL} wstate_t;

    wstate_t          state, state_nxt;
    logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
    logic             rd_bank, wr_bank, rd_bank_nxt;
    logic             rd_valid, rd_valid_nxt;
    logic             req_pend;
    logic             wr_en;
    logic [IDX_W-1:0] wr_data;
    logic [IDX_W-1:0] rd_data;
    logic             pad_q;
    logic [9:0]       next_vc, nhc;
    logic             swap_pt, swap, rd_pad;

    logic [IDX_W-1:0] mem [0:2*LINE_W-1];

    assign next_vc = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    assign swap_pt = (hc == H_END) && (next_vc >= V_FIRST) && (next_vc <= V_LASTVIS);
    // Only a bank already full before this edge may be handed to the reader.
    assign swap    = swap_pt && (state == W_FULL);

    assign wr_ready = (state == W_FILL) && !reset;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_en      = 1'b0;
        wr_data    = pix_idx;
        case (state)
            W_FILL: begin
                if (pix_valid) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    if (wr_ptr == PTR_LAST) state_nxt = W_FULL;
                    else if (pix_eol)       state_nxt = W_PAD;
                end
            end
            W_PAD: begin
                wr_en      = 1'b1;
                wr_data    = PAD_IDX;
                wr_ptr_nxt = wr_ptr + 1'b1;
                if (wr_ptr == PTR_LAST) state_nxt = W_FULL;
            end
            W_FULL: begin
                if (swap) begin
                    state_nxt  = W_FILL;
                    wr_ptr_nxt = '0;
                end
            end
            default: state_nxt = W_FILL;
        endcase
    end

    assign rd_bank_nxt  = swap ? wr_bank : rd_bank;
    assign rd_valid_nxt = rd_valid | swap;
    assign nhc          = (hc == H_END) ? 10'd0 : hc + 10'd1;
    assign rd_pad       = !rd_valid_nxt || (nhc >= LINE_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= W_FILL;
            wr_ptr   <= '0;
            rd_bank  <= 1'b0;
            wr_bank  <= 1'b1;
            rd_valid <= 1'b0;
            req_pend <= 1'b1;
            line_req <= 1'b0;
            pad_q    <= 1'b1;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_bank  <= rd_bank_nxt;
            if (swap) wr_bank <= rd_bank;
            rd_valid <= rd_valid_nxt;
            req_pend <= 1'b0;
            line_req <= req_pend | swap;
            pad_q    <= rd_pad;
            // A new error event outranks a simultaneous clear.
            overflow <= (pix_valid && !wr_ready) | (overflow & ~clr_err);
            underrun <= (swap_pt && state != W_FULL) | (underrun & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[{wr_bank, wr_ptr}] <= wr_data;
        rd_data <= mem[{rd_bank_nxt, nhc[PW-1:0]}];
    end

    assign palette_disp_idx = pad_q ? PAD_IDX : rd_data;

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Bench for ppu_line_buffer: directed scanline scenarios plus randomized lines,
// checked every cycle against a line-level reference model.
module tb_ppu_line_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic [5:0] pix_idx = '0;
    logic       pix_eol = 1'b0;
    logic       wr_ready, line_req, overflow, underrun;
    logic [9:0] hc = '0, vc = '0;
    logic [5:0] palette_disp_idx;
    logic       clr_err = 1'b0;

    always #5 clk = ~clk;

    ppu_line_buffer dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_idx(pix_idx),
        .pix_eol(pix_eol), .wr_ready(wr_ready), .line_req(line_req), .hc(hc), .vc(vc),
        .palette_disp_idx(palette_disp_idx), .overflow(overflow), .underrun(underrun),
        .clr_err(clr_err)
    );

    typedef struct {logic eol; logic [5:0] idx;} pix_t;
    pix_t wq[$];

    int n_chk = 0, n_pass = 0;
    int hc_r = 790, vc_r = 524, vc_jump = -1;
    longint cyc = 0;

    // Reference model: a pending line (pixels then padding) and the displayed line.
    bit         acc, pend, dval, m_ov, m_ur, m_lr, m_req;
    int         wn;
    longint     ready_cyc;
    logic [5:0] wline [256];
    logic [5:0] disp  [256];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (hc=%0d vc=%0d cyc=%0d)", tag, got, exp, hc_r, vc_r, cyc);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        acc = 1; wn = 0; pend = 0; dval = 0;
        m_ov = 0; m_ur = 0; m_lr = 0; m_req = 1;
        wq.delete();
    endtask

    task automatic model_edge();
        int  nv;
        bit  spt, full, lr_n;
        if (reset) begin
            model_reset();
            return;
        end
        nv   = (vc_r == 524) ? 0 : vc_r + 1;
        spt  = (hc_r == 799) && (nv >= 1) && (nv <= 240);
        full = pend && (cyc >= ready_cyc);
        lr_n = m_req;
        m_req = 0;
        if (clr_err) begin m_ov = 0; m_ur = 0; end
        if (pix_valid) begin
            if (acc) begin
                wline[wn] = pix_idx;
                wn++;
                if (wn == 256 || pix_eol) begin
                    ready_cyc = cyc + (256 - wn) + 1;  // one pad cycle per missing pixel
                    for (int k = wn; k < 256; k++) wline[k] = 6'h0F;
                    pend = 1; acc = 0;
                end
            end else m_ov = 1;
        end
        if (spt) begin
            if (full) begin
                disp = wline; dval = 1; pend = 0; acc = 1; wn = 0; lr_n = 1;
            end else m_ur = 1;
        end
        m_lr = lr_n;
    endtask

    task automatic tick();
        logic [5:0] exp_d;
        pix_valid = (wq.size() > 0);
        pix_idx   = pix_valid ? wq[0].idx : 6'h00;
        pix_eol   = pix_valid ? wq[0].eol : 1'b0;
        hc = 10'(hc_r);
        vc = 10'(vc_r);
        @(negedge clk);
        exp_d = (dval && hc_r < 256) ? disp[hc_r] : 6'h0F;
        chk("disp", palette_disp_idx, exp_d);
        chk("wr_ready", wr_ready, acc && !reset);
        chk("line_req", line_req, m_lr);
        chk("overflow", overflow, m_ov);
        chk("underrun", underrun, m_ur);
        @(posedge clk);
        model_edge();
        if (pix_valid && wq.size() > 0) void'(wq.pop_front());
        cyc++;
        if (hc_r == 799) begin
            hc_r = 0;
            vc_r = (vc_jump >= 0) ? vc_jump : ((vc_r == 524) ? 0 : vc_r + 1);
            vc_jump = -1;
        end else hc_r++;
        #1;
    endtask

    task automatic push_line(int n, int pat);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.idx = (pat == 1) ? 6'(k) : (pat == 2) ? 6'h21 : 6'($urandom);
            p.eol = (k == n - 1) ? ((n < 256) || ($urandom_range(0, 1) == 1)) : 1'b0;
            wq.push_back(p);
        end
    endtask

    task automatic run_line(int n, int start, int pat, int clr_at, int ovf_at);
        pix_t p;
        for (int h = 0; h < 800; h++) begin
            if (n > 0 && h == start) push_line(n, pat);
            if (h == ovf_at) begin
                p.idx = 6'($urandom); p.eol = 1'b0;
                wq.push_back(p);
            end
            clr_err = (h == clr_at);
            tick();
        end
        clr_err = 1'b0;
    endtask

    task automatic do_reset(int ncyc);
        reset = 1'b1;
        #1;
        model_reset();
        repeat (ncyc) tick();
        reset = 1'b0;
    endtask

    initial begin
        int n, st, ca, oa;
        model_reset();
        repeat (5) tick();             // reset held, hc 790..794
        reset = 1'b0;
        repeat (5) tick();             // hc 795..799; vc wraps to 0
        run_line(256, 0, 1, -1, -1);   // vc0: ramp line, swap at end
        run_line(10, 0, 2, -1, -1);    // vc1: short line of 0x21
        run_line(0, 0, 0, -1, -1);     // vc2: nothing written -> underrun
        run_line(256, 0, 0, 400, 400); // vc3: clear + new overflow on same edge
        run_line(256, 544, 0, 50, -1); // vc4: fills on the swap edge -> waits
        run_line(0, 0, 0, -1, -1);     // vc5: pending line swaps here
        push_line(100, 0);             // vc6: reset while padding
        repeat (150) tick();
        do_reset(3);
        repeat (647) tick();
        run_line(256, 0, 0, -1, -1);   // vc7
        for (int i = 0; i < 18; i++) begin
            n  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 256);
            st = $urandom_range(0, 700);
            ca = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 799) : -1;
            oa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 799) : -1;
            case ($urandom_range(0, 7))
                0: vc_jump = 239;
                1: vc_jump = 523;
                2: vc_jump = $urandom_range(0, 524);
                default: vc_jump = -1;
            endcase
            run_line(n, st, 0, ca, oa);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
